// File: rtl/min_max_finder_param_if.sv
// Handshake, write port and result bus of the parametrised min/max finder.
// The master modport drives commands and array writes; the slave modport is the finder itself.
interface min_max_finder_param_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int AW = $clog2(DEPTH);

  logic              Start;
  logic              Ack;
  logic [AW:0]       Len;
  logic              Wr_En;
  logic [AW-1:0]     Wr_Addr;
  logic [DATA_W-1:0] Wr_Data;
  logic [DATA_W-1:0] Max;
  logic [DATA_W-1:0] Min;
  logic [AW-1:0]     Max_Idx;
  logic [AW-1:0]     Min_Idx;
  logic              Qi;
  logic              Ql;
  logic              Qc;
  logic              Qd;

  modport master (
    output Start, Ack, Len, Wr_En, Wr_Addr, Wr_Data,
    input  Max, Min, Max_Idx, Min_Idx, Qi, Ql, Qc, Qd
  );

  modport slave (
    input  Start, Ack, Len, Wr_En, Wr_Addr, Wr_Data,
    output Max, Min, Max_Idx, Min_Idx, Qi, Ql, Qc, Qd
  );
endinterface

// File: rtl/min_max_finder_param.sv
// Scans a prefix of an internal DATA_W x DEPTH array and reports max/min with first-occurrence indices.
// Define MMF_SIGNED_EN to compare elements as two's-complement values (unsigned otherwise).
module min_max_finder_param #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                    Clk,
  input  logic                    Reset,
  min_max_finder_param_if.slave   bus
);
  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE     = (AW+1)'(1);

  typedef enum logic [3:0] {
    S_INI  = 4'b0001,
    S_LOAD = 4'b0010,
    S_COMP = 4'b0100,
    S_DONE = 4'b1000
  } state_t;

  state_t            state_q, state_d;
  logic [AW:0]       i_q, i_d;
  logic [AW:0]       n_q, n_d;
  logic [DATA_W-1:0] max_q, max_d;
  logic [DATA_W-1:0] min_q, min_d;
  logic [AW-1:0]     max_idx_q, max_idx_d;
  logic [AW-1:0]     min_idx_q, min_idx_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [DATA_W-1:0] elem;
  logic [AW:0]       len_eff;

  function automatic logic is_gt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
`ifdef MMF_SIGNED_EN
    logic signed [DATA_W-1:0] sa;
    logic signed [DATA_W-1:0] sb;
    sa = a;
    sb = b;
    return sa > sb;
`else
    return a > b;
`endif
  endfunction

  function automatic logic is_lt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
`ifdef MMF_SIGNED_EN
    logic signed [DATA_W-1:0] sa;
    logic signed [DATA_W-1:0] sb;
    sa = a;
    sb = b;
    return sa < sb;
`else
    return a < b;
`endif
  endfunction

  // Zero and oversize lengths both mean "scan the whole array".
  assign len_eff = ((bus.Len == '0) || (bus.Len > LEN_MAX)) ? LEN_MAX : bus.Len;
  assign elem    = mem_q[i_q[AW-1:0]];

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    n_d       = n_q;
    max_d     = max_q;
    min_d     = min_q;
    max_idx_d = max_idx_q;
    min_idx_d = min_idx_q;
    case (state_q)
      S_INI: begin
        i_d = '0;
        if (bus.Start) begin
          n_d     = len_eff;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        max_d     = mem_q[0];
        min_d     = mem_q[0];
        max_idx_d = '0;
        min_idx_d = '0;
        i_d       = ONE;
        state_d   = (n_q == ONE) ? S_DONE : S_COMP;
      end
      S_COMP: begin
        // Strict comparisons keep the earliest index on ties.
        if (is_gt(elem, max_q)) begin
          max_d     = elem;
          max_idx_d = i_q[AW-1:0];
        end
        if (is_lt(elem, min_q)) begin
          min_d     = elem;
          min_idx_d = i_q[AW-1:0];
        end
        if (i_q == n_q - ONE) state_d = S_DONE;
        else                  i_d     = i_q + ONE;
      end
      S_DONE: begin
        if (bus.Ack) state_d = S_INI;
      end
      default: state_d = S_INI;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_INI;
      i_q       <= '0;
      n_q       <= LEN_MAX;
      max_q     <= '0;
      min_q     <= '0;
      max_idx_q <= '0;
      min_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      n_q       <= n_d;
      max_q     <= max_d;
      min_q     <= min_d;
      max_idx_q <= max_idx_d;
      min_idx_q <= min_idx_d;
    end
  end

  // Array survives reset so an aborted scan can be rerun on the same data.
  always_ff @(posedge Clk) begin
    if (state_q == S_INI && bus.Wr_En) mem_q[bus.Wr_Addr] <= bus.Wr_Data;
  end

  assign bus.Max     = max_q;
  assign bus.Min     = min_q;
  assign bus.Max_Idx = max_idx_q;
  assign bus.Min_Idx = min_idx_q;
  assign bus.Qi      = state_q[0];
  assign bus.Ql      = state_q[1];
  assign bus.Qc      = state_q[2];
  assign bus.Qd      = state_q[3];
endmodule

// File: tb/tb_min_max_finder_param.sv
// Scoreboard bench for min_max_finder_param: a reference scan of a shadow array is queued per Start
// and popped when the finder raises Qd.
module tb_min_max_finder_param;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int AW     = $clog2(DEPTH);
  localparam int RW     = 2*DATA_W + 2*AW;
  localparam int BOUND  = 200;

  typedef logic [RW-1:0] res_t;

  logic Clk = 1'b0;
  logic Reset;
  int   checks = 0;
  int   errors = 0;

  logic [DATA_W-1:0] mm [DEPTH];
  res_t              sb_q [$];

  min_max_finder_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  min_max_finder_param #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit m_gt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
`ifdef MMF_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  function automatic int eff_n(input int len);
    return (len == 0 || len > DEPTH) ? DEPTH : len;
  endfunction

  function automatic res_t model(input int n);
    logic [DATA_W-1:0] mx, mn;
    logic [AW-1:0]     xi, ni;
    mx = mm[0]; mn = mm[0]; xi = '0; ni = '0;
    for (int k = 1; k < n; k++) begin
      if (m_gt(mm[k], mx)) begin mx = mm[k]; xi = AW'(k); end
      if (m_gt(mn, mm[k])) begin mn = mm[k]; ni = AW'(k); end
    end
    return {mx, xi, mn, ni};
  endfunction

  function automatic res_t got();
    return {bus.Max, bus.Max_Idx, bus.Min, bus.Min_Idx};
  endfunction

  task automatic wr(input int a, input int d);
    bus.Wr_En   = 1'b1;
    bus.Wr_Addr = AW'(a);
    bus.Wr_Data = DATA_W'(d);
    @(posedge Clk); #1;
    bus.Wr_En = 1'b0;
    mm[a] = DATA_W'(d);
  endtask

  task automatic run_scan(input int len, output int cyc);
    bus.Len = (AW+1)'(len);
    sb_q.push_back(model(eff_n(len)));
    bus.Start = 1'b1;
    cyc = 0;
    do begin
      @(posedge Clk); #1;
      bus.Start = 1'b0;
      bus.Wr_En = 1'b0;
      cyc++;
    end while (bus.Qd !== 1'b1 && cyc < BOUND);
  endtask

  task automatic do_ack();
    bus.Ack = 1'b1;
    @(posedge Clk); #1;
    bus.Ack = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    checks++;
    if ({bus.Qd, bus.Qc, bus.Ql, bus.Qi} !== 4'b0001) begin
      errors++; $display("FAIL reset_state: got %b expected 0001", {bus.Qd, bus.Qc, bus.Ql, bus.Qi});
    end
    checks++;
    if (got() !== '0) begin
      errors++; $display("FAIL reset_result: got %h expected 0", got());
    end
  endtask

  task automatic test_ascending();
    int cyc; res_t e;
    for (int k = 0; k < DEPTH; k++) wr(k, k);
    run_scan(16, cyc);
    checks++;
    if (cyc !== 17) begin errors++; $display("FAIL asc_latency: got %0d expected 17", cyc); end
    e = sb_q.pop_front();
    checks++;
    if (got() !== {8'h0F, 4'hF, 8'h00, 4'h0}) begin
      errors++; $display("FAIL asc_result: got %h expected %h", got(), {8'h0F, 4'hF, 8'h00, 4'h0});
    end
    checks++;
    if (got() !== e) begin errors++; $display("FAIL asc_sb: got %h expected %h", got(), e); end
    do_ack();
    checks++;
    if (bus.Qi !== 1'b1 || got() !== e) begin
      errors++; $display("FAIL asc_hold_in_ini: got Qi=%b %h expected Qi=1 %h", bus.Qi, got(), e);
    end
  endtask

  task automatic test_ties();
    int cyc; res_t e;
    for (int k = 0; k < DEPTH; k++) wr(k, 5);
    wr(0, 7); wr(1, 3); wr(2, 9); wr(3, 3); wr(4, 9);
    run_scan(16, cyc);
    e = sb_q.pop_front();
    checks++;
    if (got() !== {8'h09, 4'h2, 8'h03, 4'h1}) begin
      errors++; $display("FAIL ties_result: got %h expected %h", got(), {8'h09, 4'h2, 8'h03, 4'h1});
    end
    checks++;
    if (got() !== e) begin errors++; $display("FAIL ties_sb: got %h expected %h", got(), e); end
    do_ack();
  endtask

  task automatic test_len_edges();
    int cyc; res_t e;
    wr(0, 8'hA5);
    run_scan(1, cyc);
    e = sb_q.pop_front();
    checks++;
    if (cyc !== 2) begin errors++; $display("FAIL len1_latency: got %0d expected 2", cyc); end
    checks++;
    if (got() !== {8'hA5, 4'h0, 8'hA5, 4'h0}) begin
      errors++; $display("FAIL len1_result: got %h expected %h", got(), {8'hA5, 4'h0, 8'hA5, 4'h0});
    end
    do_ack();
    run_scan(0, cyc);
    e = sb_q.pop_front();
    checks++;
    if (cyc !== 17) begin errors++; $display("FAIL len0_latency: got %0d expected 17", cyc); end
    checks++;
    if (got() !== e) begin errors++; $display("FAIL len0_result: got %h expected %h", got(), e); end
    do_ack();
  endtask

  task automatic test_signed_pattern();
    int cyc; res_t e; res_t c;
`ifdef MMF_SIGNED_EN
    c = {8'h7F, 4'h0, 8'h80, 4'h1};
`else
    c = {8'hFF, 4'h3, 8'h00, 4'h4};
`endif
    for (int k = 4; k < DEPTH; k++) wr(k, 0);
    wr(0, 8'h7F); wr(1, 8'h80); wr(2, 8'h01); wr(3, 8'hFF);
    run_scan(16, cyc);
    e = sb_q.pop_front();
    checks++;
    if (got() !== c) begin errors++; $display("FAIL sign_result: got %h expected %h", got(), c); end
    checks++;
    if (got() !== e) begin errors++; $display("FAIL sign_sb: got %h expected %h", got(), e); end
    do_ack();
  endtask

  task automatic test_reset_mid_comp();
    int cyc; res_t e;
    bus.Len   = 5'd16;
    bus.Start = 1'b1;
    @(posedge Clk); #1;
    bus.Start = 1'b0;
    repeat (6) @(posedge Clk);
    #1;
    checks++;
    if (bus.Qc !== 1'b1) begin errors++; $display("FAIL rst_mid_in_comp: got Qc=%b expected 1", bus.Qc); end
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    checks++;
    if ({bus.Qd, bus.Qc, bus.Ql, bus.Qi} !== 4'b0001 || bus.Max !== '0 || bus.Min !== '0) begin
      errors++; $display("FAIL rst_mid_abort: got state %b max %h min %h expected 0001 00 00",
                         {bus.Qd, bus.Qc, bus.Ql, bus.Qi}, bus.Max, bus.Min);
    end
    run_scan(16, cyc);
    e = sb_q.pop_front();
    checks++;
    if (got() !== e) begin errors++; $display("FAIL rst_mid_rescan: got %h expected %h", got(), e); end
    do_ack();
  endtask

  task automatic test_write_in_comp();
    int cyc; res_t e;
    for (int k = 0; k < DEPTH; k++) wr(k, k);
    bus.Len = 5'd16;
    sb_q.push_back(model(16));
    bus.Start = 1'b1;
    @(posedge Clk); #1;
    bus.Start = 1'b0;
    @(posedge Clk); #1;
    bus.Wr_En = 1'b1; bus.Wr_Addr = 4'd10; bus.Wr_Data = 8'hFF;
    @(posedge Clk); #1;
    bus.Wr_En = 1'b0;
    cyc = 0;
    while (bus.Qd !== 1'b1 && cyc < BOUND) begin @(posedge Clk); #1; cyc++; end
    e = sb_q.pop_front();
    checks++;
    if (got() !== e) begin errors++; $display("FAIL wr_in_comp: got %h expected %h", got(), e); end
    do_ack();
  endtask

  task automatic test_write_with_start();
    int cyc; res_t e;
    bus.Wr_En = 1'b1; bus.Wr_Addr = 4'd0; bus.Wr_Data = 8'hC3;
    mm[0] = 8'hC3;
    run_scan(16, cyc);
    e = sb_q.pop_front();
    checks++;
    if (got() !== e) begin errors++; $display("FAIL wr_with_start: got %h expected %h", got(), e); end
    do_ack();
  endtask

  task automatic test_done_hold();
    int cyc; res_t e; int bad;
    run_scan(8, cyc);
    e = sb_q.pop_front();
    checks++;
    if (cyc !== 9) begin errors++; $display("FAIL hold_latency: got %0d expected 9", cyc); end
    checks++;
    if (got() !== e) begin errors++; $display("FAIL hold_result: got %h expected %h", got(), e); end
    bus.Start = 1'b1;
    bus.Len   = 5'd3;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge Clk); #1;
      if (k == 0) bus.Start = 1'b0;
      checks++;
      if (bus.Qd !== 1'b1 || got() !== e) begin
        errors++; bad++;
        if (bad < 4) $display("FAIL hold_cycle%0d: got Qd=%b %h expected Qd=1 %h", k, bus.Qd, got(), e);
      end
    end
    do_ack();
    checks++;
    if ({bus.Qd, bus.Qi} !== 2'b01) begin
      errors++; $display("FAIL hold_ack: got Qd=%b Qi=%b expected Qd=0 Qi=1", bus.Qd, bus.Qi);
    end
  endtask

  task automatic test_back_to_back();
    int cyc; int len; res_t e;
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < DEPTH; k++) wr(k, int'($urandom_range(0, 255)));
      len = (r == 0) ? 31 : int'($urandom_range(0, 31));
      run_scan(len, cyc);
      e = sb_q.pop_front();
      checks++;
      if (cyc !== eff_n(len) + 1) begin
        errors++; $display("FAIL b2b%0d_latency: got %0d expected %0d (len %0d)", r, cyc, eff_n(len) + 1, len);
      end
      checks++;
      if (got() !== e) begin errors++; $display("FAIL b2b%0d_result: got %h expected %h", r, got(), e); end
      do_ack();
    end
  endtask

  initial begin
    Reset = 1'b1;
    bus.Start = 1'b0; bus.Ack = 1'b0; bus.Len = '0;
    bus.Wr_En = 1'b0; bus.Wr_Addr = '0; bus.Wr_Data = '0;
    for (int k = 0; k < DEPTH; k++) mm[k] = '0;
    test_reset();
    test_ascending();
    test_ties();
    test_len_edges();
    test_signed_pattern();
    test_reset_mid_comp();
    test_write_in_comp();
    test_write_with_start();
    test_done_hold();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
